// File: rtl/a2d_pkg.sv
// Shared types and command-field constants for the A2D channel-sweep sequencer.
package a2d_pkg;

    localparam int unsigned MAX_CHNL   = 8;
    localparam int unsigned CMD_W      = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CMD_CH_LSB = 11;
    localparam int unsigned CMD_CH_W   = 3;
    localparam int unsigned RES_W      = 12;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CH,
        WAIT_CH,
        SEND_RD,
        WAIT_RD,
        STORE
    } state_t;

    // Channel-select command word: channel in [13:11], everything else zero.
    function automatic logic [CMD_W-1:0] ch_cmd(input logic [CMD_CH_W-1:0] ch);
        logic [CMD_W-1:0] w;
        w = '0;
        w[CMD_CH_LSB +: CMD_CH_W] = ch;
        return w;
    endfunction

endpackage

// File: rtl/a2d_res_file.sv
// NUM_CHNL x RES_W result registers; one write port, asynchronous read that returns 0 out of range.
module a2d_res_file
    import a2d_pkg::*;
#(
    parameter int unsigned NUM_CHNL = MAX_CHNL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [CMD_CH_W-1:0] wr_idx,
    input  logic [RES_W-1:0]    wr_val,
    input  logic [CMD_CH_W-1:0] rd_idx,
    output logic [RES_W-1:0]    rd_val
);

    logic [RES_W-1:0] mem [NUM_CHNL];

    for (genvar i = 0; i < NUM_CHNL; i++) begin : g_ent
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[i] <= '0;
            end else if (we && (wr_idx == CMD_CH_W'(i))) begin
                mem[i] <= wr_val;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_CHNL; i++) begin
            if (rd_idx == CMD_CH_W'(i)) begin
                rd_val = mem[i];
            end
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Sweeps channels 0..NUM_CHNL-1 through the SPI master, two transactions per channel,
// and keeps the latest 12-bit conversion of each channel in a readable result file.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter int unsigned NUM_CHNL = MAX_CHNL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                strt,
    output logic                busy,
    output logic                cnv_cmplt,
    input  logic [CMD_CH_W-1:0] rd_chnl,
    output logic [RES_W-1:0]    res,
    output logic                wrt,
    output logic [CMD_W-1:0]    cmd,
    input  logic                done,
    input  logic [DATA_W-1:0]   rd_data
);

    localparam logic [CMD_CH_W-1:0] LAST_CH = CMD_CH_W'(NUM_CHNL - 1);

    state_t              state_q, state_d;
    logic [CMD_CH_W-1:0] ch_q, ch_d;
    logic                busy_q, busy_d;
    logic                cnv_q, cnv_d;
    logic                wrt_q, wrt_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                store_c;

    // Status nibble of the SPI word carries no conversion data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[DATA_W-1:RES_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            cnv_q   <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            cnv_q   <= cnv_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        busy_d  = busy_q;
        cnv_d   = cnv_q;
        store_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (strt) begin
                    state_d = SEND_CH;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    cnv_d   = 1'b0;
                end
            end
            SEND_CH: state_d = WAIT_CH;
            WAIT_CH: if (done) state_d = SEND_RD;
            SEND_RD: state_d = WAIT_RD;
            WAIT_RD: if (done) state_d = STORE;
            STORE: begin
                store_c = 1'b1;
                if (ch_q == LAST_CH) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnv_d   = 1'b1;
                end else begin
                    state_d = SEND_CH;
                    ch_d    = CMD_CH_W'(ch_q + CMD_CH_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        // wrt/cmd are registered, so they are decoded from the state being entered.
        wrt_d = (state_d == SEND_CH) || (state_d == SEND_RD);
        cmd_d = wrt_d ? ch_cmd(ch_d) : cmd_q;
    end

    a2d_res_file #(
        .NUM_CHNL (NUM_CHNL)
    ) u_res_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (store_c),
        .wr_idx (ch_q),
        .wr_val (rd_data[RES_W-1:0]),
        .rd_idx (rd_chnl),
        .rd_val (res)
    );

    assign busy      = busy_q;
    assign cnv_cmplt = cnv_q;
    assign wrt       = wrt_q;
    assign cmd       = cmd_q;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Randomized bench for a2d_scan_ctrl: SPI slave model with random latency and a per-channel result model.
module tb_a2d_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  strt, busy, cnv, wrt, done;
    logic [2:0]  rd_chnl [2];
    logic [11:0] res     [2];
    logic [15:0] cmd     [2];
    logic [15:0] rd_data [2];

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic [1:0]  tog, cur_rd, pend;
    logic [1:0]  lat [2];
    logic [2:0]  sch [2];
    logic        slave_mode, slave_hi_f;
    logic [11:0] slave_val;
    logic [1:0]  prev_wrt;

    // Expected result file per instance
    logic [11:0] exp_res [2][8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    a2d_scan_ctrl #(.NUM_CHNL(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .strt(strt[0]), .busy(busy[0]), .cnv_cmplt(cnv[0]),
        .rd_chnl(rd_chnl[0]), .res(res[0]), .wrt(wrt[0]), .cmd(cmd[0]),
        .done(done[0]), .rd_data(rd_data[0])
    );

    a2d_scan_ctrl #(.NUM_CHNL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .strt(strt[1]), .busy(busy[1]), .cnv_cmplt(cnv[1]),
        .rd_chnl(rd_chnl[1]), .res(res[1]), .wrt(wrt[1]), .cmd(cmd[1]),
        .done(done[1]), .rd_data(rd_data[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nch_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    // Conversion value the A2D reports for a channel under the current slave setting.
    function automatic logic [11:0] conv_word(input int ch);
        return slave_mode ? slave_val : 12'(12'h0A5 + ch);
    endfunction

    // SPI slave: done drops after wrt, rises 1..4 cycles later; every second transaction returns the result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                done[k]    <= 1'b0;
                rd_data[k] <= 16'h0000;
                tog[k]     <= 1'b0;
                cur_rd[k]  <= 1'b0;
                pend[k]    <= 1'b0;
                lat[k]     <= 2'd0;
                sch[k]     <= 3'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wrt[k]) begin
                    done[k]   <= 1'b0;
                    pend[k]   <= 1'b1;
                    lat[k]    <= 2'($urandom_range(0, 3));
                    cur_rd[k] <= tog[k];
                    tog[k]    <= ~tog[k];
                    sch[k]    <= cmd[k][13:11];
                end else if (pend[k]) begin
                    if (lat[k] == 2'd0) begin
                        done[k] <= 1'b1;
                        pend[k] <= 1'b0;
                        if (cur_rd[k])
                            rd_data[k] <= {(slave_hi_f ? 4'hF : 4'($urandom)), conv_word(int'(sch[k]))};
                        else
                            rd_data[k] <= 16'($urandom);
                    end else begin
                        lat[k] <= lat[k] - 2'd1;
                    end
                end
            end
        end
    end

    // Protocol monitor: wrt spacing, command format, busy/cnv_cmplt exclusivity.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wrt[k]) begin
                check("wrt_b2b", 32'(prev_wrt[k]), 32'(0));
                check("cmd_fmt", 32'({cmd[k][15:14], cmd[k][10:0]}), 32'(0));
            end
            if (busy[k] | cnv[k])
                check("busy_cnv_excl", 32'(busy[k] & cnv[k]), 32'(0));
            prev_wrt[k] = wrt[k];
        end
    end

    task automatic check_results(input int k);
        for (int i = 0; i < 8; i++) begin
            rd_chnl[k] = 3'(i);
            #1;
            check($sformatf("res%0d_ch%0d", k, i), 32'(res[k]),
                  32'((i < nch_of(k)) ? exp_res[k][i] : 12'h000));
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            check("rst_wrt",  32'(wrt[k]),  32'(0));
            check("rst_cmd",  32'(cmd[k]),  32'(0));
            check("rst_busy", 32'(busy[k]), 32'(0));
            check("rst_cnv",  32'(cnv[k]),  32'(0));
        end
    endtask

    // One scan on instance k; optional strt re-pulse at channel 4, optional reset in WAIT_RD of channel 2.
    task automatic run_scan(input int k, input bit inject, input bit abort);
        int n;
        bit got;
        logic [2:0] seen [$];
        got = 1'b0;
        strt[k] = 1'b1;
        @(negedge clk);
        strt[k] = 1'b0;
        check("strt_busy", 32'(busy[k]), 32'(1));
        check("strt_cnv_clr", 32'(cnv[k]), 32'(0));
        check("first_wrt", 32'(wrt[k]), 32'(1));
        n = 1;
        seen.push_back(cmd[k][13:11]);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            strt[k] = 1'b0;
            if (wrt[k]) begin
                n++;
                seen.push_back(cmd[k][13:11]);
                if (inject && n == 9) strt[k] = 1'b1;
                if (abort && n == 6) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    return;
                end
            end
            if (cnv[k]) begin
                got = 1'b1;
                break;
            end
        end
        check("scan_tmo", 32'(cnv[k]), 32'(1));
        if (!got) return;
        check("wrt_count", 32'(n), 32'(2 * nch_of(k)));
        for (int i = 0; i < seen.size(); i++)
            check("cmd_ch", 32'(seen[i]), 32'(i / 2));
        check("end_busy", 32'(busy[k]), 32'(0));
        for (int ch = 0; ch < nch_of(k); ch++)
            exp_res[k][ch] = conv_word(ch);
        check_results(k);
    endtask

    initial begin
        strt       = 2'b00;
        rd_chnl[0] = 3'd0;
        rd_chnl[1] = 3'd0;
        slave_mode = 1'b0;
        slave_hi_f = 1'b0;
        slave_val  = 12'h000;
        prev_wrt   = 2'b00;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                exp_res[k][i] = 12'h000;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        check_results(0);
        check_results(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sweep: result = 0x0A5 + channel
        run_scan(0, 1'b0, 1'b0);
        rd_chnl[0] = 3'd3;
        #1;
        check("res_ch3_0a8", 32'(res[0]), 32'(12'h0A8));
        @(negedge clk);

        // Status nibble forced to F must not leak into results
        slave_mode = 1'b1;
        slave_val  = 12'h123;
        slave_hi_f = 1'b1;
        run_scan(0, 1'b0, 1'b0);
        slave_hi_f = 1'b0;

        // strt during busy is ignored
        slave_mode = 1'b0;
        run_scan(0, 1'b1, 1'b0);

        // Reset in WAIT_RD of channel 2
        slave_mode = 1'b1;
        slave_val  = 12'h777;
        run_scan(0, 1'b0, 1'b1);
        #1;
        check_reset_outputs();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                exp_res[k][i] = 12'h000;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_wrt", 32'(wrt[0]), 32'(0));
        end
        check_results(0);
        check_results(1);
        rst_n = 1'b1;
        @(negedge clk);
        slave_mode = 1'b0;
        run_scan(0, 1'b0, 1'b0);

        // Single-channel instance
        run_scan(1, 1'b0, 1'b0);
        rd_chnl[1] = 3'd5;
        #1;
        check("n1_ch5_zero", 32'(res[1]), 32'(12'h000));
        @(negedge clk);

        // Back-to-back scans with slave switched to 0xFFF
        run_scan(0, 1'b0, 1'b0);
        slave_mode = 1'b1;
        slave_val  = 12'hFFF;
        run_scan(0, 1'b0, 1'b0);

        // Randomized scans
        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(0, 1));
            slave_mode = 1'($urandom);
            slave_val  = 12'($urandom);
            slave_hi_f = 1'($urandom);
            run_scan(k, (k == 0) ? 1'($urandom) : 1'b0, 1'b0);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_scan_ctrl.md
# a2d_scan_ctrl

Channel-sweep sequencer that sits directly upstream of the team's 16-bit SPI master and drives it to read an 8-channel, 12-bit SPI A2D converter. On a start pulse it converts channels 0..NUM_CHNL-1 in order, using two SPI transactions per channel, and stores each 12-bit result in an internal result register file. Downstream logic reads the results by channel index.

## Interface
- NUM_CHNL, 8, number of channels swept per scan; legal range 1..8.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- strt  in  1  start a scan; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted strt until the scan finishes.
- cnv_cmplt  out  1  set/reset flag; set at scan end, cleared when a strt is accepted.
- rd_chnl  in  3  result read index.
- res  out  12  combinational read of result[rd_chnl]; reads 12'h000 when rd_chnl ≥ NUM_CHNL.
- wrt  out  1  one-cycle pulse to the SPI master, registered.
- cmd  out  16  command word to the SPI master, registered; valid in every cycle wrt is high.
- done  in  1  SPI master set/reset done flag; it goes low the cycle after wrt.
- rd_data  in  16  word shifted in on MISO; valid while done is high.

## Operation
- States: IDLE, SEND_CH, WAIT_CH, SEND_RD, WAIT_RD, STORE.
- IDLE + strt goes to SEND_CH, clears ch_cnt to 0, clears cnv_cmplt and sets busy. strt is ignored in every other state.
- SEND_CH: wrt=1, cmd={2'b00, ch_cnt[2:0], 11'h000}, then go to WAIT_CH.
- WAIT_CH: hold until done=1, then go to SEND_RD. Never sample done in the cycle wrt is high.
- SEND_RD: wrt=1, cmd is the same channel word, then go to WAIT_RD. The second transaction clocks out the conversion result.
- WAIT_RD: hold until done=1, then go to STORE.
- STORE: result[ch_cnt] <= rd_data[11:0]; rd_data[15:12] is discarded.
  - If ch_cnt == NUM_CHNL-1: set cnv_cmplt, clear busy, go to IDLE.
  - Otherwise: ch_cnt+1 and go to SEND_CH.
- ch_cnt is 3 bits and never wraps within a scan. A new scan always restarts at channel 0.
- The result file is not cleared by strt. Stale values remain readable until overwritten.

## Timing
- Reset values: wrt=0, cmd=16'h0000, busy=0, cnv_cmplt=0, all results 12'h000, state IDLE, ch_cnt=0.
- Reset asserted mid-scan aborts immediately with no further wrt. The SPI master is reset by the same rst_n.
- strt to first wrt is 1 cycle. wrt is never high in two consecutive cycles.
- SEND_RD wrt follows the cycle after WAIT_CH sees done.
- The result is written on the clk edge ending STORE. res shows it in the next cycle.
- Per channel: 2 SPI transactions + 4 control cycles. cnv_cmplt rises one cycle after the last STORE.
- busy and cnv_cmplt are never both high.

## Structure
- Shared package a2d_pkg holds:
  - the state typedef;
  - the command field constants: CMD_CH_LSB=11, CMD_CH_W=3, RES_W=12;
  - the NUM_CHNL maximum of 8.
- One natural sub-module: a2d_res_file, a NUM_CHNL×12 register file with write enable, write index and async read port.

## Test plan
- SPI slave model returning 12'h0A5 + ch; strt pulse → 16 wrt pulses; cmd bits[13:11] = 0,0,1,1,…,7,7; cnv_cmplt rises; res for rd_chnl=3 is 12'h0A8.
- rd_data[15:12] driven to 4'hF during the read transaction → stored result keeps upper bits clear (e.g. 16'hF123 stores 12'h123).
- strt pulsed again during busy at channel 4 → ignored; exactly 16 wrt total; ch_cnt sequence unchanged.
- rst_n dropped while in WAIT_RD for channel 2 → all outputs reset, results 12'h000; a new strt completes a full scan normally.
- NUM_CHNL=1 → 2 wrt pulses only; cnv_cmplt set; rd_chnl=5 reads 12'h000.
- Back-to-back scans with slave value changed to 12'hFFF → cnv_cmplt clears on the second strt; all results read 12'hFFF after it sets again.
